// File: rtl/div_control.sv
// ---------------------------------------------------------------------------
// div_control
//
// Iterative signed integer divider for the multdiv unit. A one-cycle start
// pulse latches the operands. The divider then runs one restoring-division
// step per clock on the operand magnitudes, and applies sign correction to the
// quotient on the last step.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   ctrl_DIV        start pulse; sampled on the rising clock edge
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   data_result     quotient, two's complement, registered; held between ops
//   data_exception  divide-by-zero flag, registered; held between ops
//   data_resultRDY  one-cycle result-valid strobe, registered
//   busy            high while an operation is iterating (RUN state)
//
// Timing
//   A start sampled at edge E0 with a non-zero divisor raises data_resultRDY
//   on edge E(WIDTH) for exactly one cycle. A zero divisor raises it on E0.
//   A start while RUN or DONE abandons the current operation silently and
//   begins the new one.
//
// CNT_W must satisfy 2**CNT_W > WIDTH so the step counter can reach WIDTH-1.
// ---------------------------------------------------------------------------
module div_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value during the final restoring step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] quo_q;     // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dsr_q;     // divisor magnitude
  logic             neg_q;     // quotient must be negated at the end
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH-1:0] absA_d;
  logic [WIDTH-1:0] absB_d;
  logic             divZero_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             trialOk_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quoSigned_d;

  // Operand magnitudes. Negating the most negative value wraps back to
  // 2^(WIDTH-1). Read as unsigned, that is its true magnitude, so WIDTH bits
  // are enough and no separate wide path is needed.
  always_comb begin
    absA_d    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    absB_d    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    divZero_d = (data_operandB == '0);
  end

  // One restoring step.
  // The remainder is always below the divisor, and the divisor is at most
  // 2^(WIDTH-1). So the shifted remainder fits in WIDTH bits. The trial
  // subtraction in WIDTH+1 bits then has a reliable sign bit.
  always_comb begin
    shifted_d   = {rem_q, quo_q[WIDTH-1]};
    trial_d     = shifted_d - {1'b0, dsr_q};
    trialOk_d   = ~trial_d[WIDTH];
    rem_d       = trialOk_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    quo_d       = {quo_q[WIDTH-2:0], trialOk_d};
    quoSigned_d = neg_q ? (~quo_d + 1'b1) : quo_d;
  end

  // Control FSM and datapath registers.
  // A start pulse has priority in every state, which is what makes a
  // re-trigger abort the operation in flight. The ready strobe defaults low,
  // so it only lives for the single cycle after it is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_DIV) begin
        cnt_q <= '0;
        rem_q <= '0;
        if (divZero_d) begin
          // Nothing to iterate: report the exception right away.
          state_q  <= DONE;
          quo_q    <= '0;
          dsr_q    <= '0;
          neg_q    <= 1'b0;
          result_q <= '0;
          exc_q    <= 1'b1;
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
        end else begin
          state_q <= RUN;
          quo_q   <= absA_d;
          dsr_q   <= absB_d;
          neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q  <= DONE;
              result_q <= quoSigned_d;
              exc_q    <= 1'b0;
              rdy_q    <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_control.sv
// ---------------------------------------------------------------------------
// tb_div_control
//
// Self-checking bench for div_control (WIDTH=32). Expected quotients come
// from plain signed 64-bit division, truncated to 32 bits. Directed cases
// cover signs, boundaries, divide-by-zero, abort and reset mid-operation.
// Random operand pairs follow the directed cases.
// ---------------------------------------------------------------------------
module tb_div_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_control #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  // One comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: signed division truncating toward zero, done in
  // 64 bits and wrapped to 32. A zero divisor gives the exception with
  // a zero quotient.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic exc);
    longint sa;
    longint sb;
    longint sq;
    if (b == 32'd0) begin
      q   = 32'd0;
      exc = 1'b1;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sq  = sa / sb;
      q   = sq[31:0];
      exc = 1'b0;
    end
  endfunction

  // Pulse ctrl_DIV for one edge with the given operands. Afterwards, scramble
  // the operand inputs so that any late sampling shows up as a wrong result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait for the ready strobe of the operation accepted on the last edge.
  // Then check its latency, quotient, flag and busy time. Finally check that
  // the strobe drops while the outputs hold.
  task automatic awaitResult(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] expQ;
    logic        expE;
    int          lat;
    int          busyCnt;
    refModel(a, b, expQ, expE);
    lat     = -1;
    busyCnt = 0;
    for (int k = 0; k < 100 && lat < 0; k++) begin
      @(negedge clk);
      if (data_resultRDY) lat = k;
      else if (busy) busyCnt++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
    checkOutput({tag, ".result"}, data_result, expQ);
    checkOutput({tag, ".exception"}, 32'(data_exception), 32'(expE));
    checkOutput({tag, ".busyCycles"}, 32'(busyCnt), (b == 32'd0) ? 32'd0 : 32'd32);
    @(negedge clk);
    checkOutput({tag, ".rdyDrop"}, 32'(data_resultRDY), 32'd0);
    checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
    checkOutput({tag, ".hold"}, data_result, expQ);
  endtask

  task automatic runDivide(input logic [31:0] a, input logic [31:0] b, input string tag);
    applyStimulus(a, b);
    awaitResult(a, b, tag);
  endtask

  initial begin
    int          strobes;
    logic [31:0] ra;
    logic [31:0] rb;

    reset         = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;

    // Power-on reset across a few edges.
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.result", data_result, 32'd0);
    checkOutput("reset.exception", 32'(data_exception), 32'd0);
    checkOutput("reset.rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    $display("[TB] reset released");

    // Main function and sign cases.
    runDivide(32'd100, 32'd7, "pos_pos");
    runDivide(-32'sd100, 32'd7, "neg_pos");
    runDivide(32'd100, -32'sd7, "pos_neg");
    runDivide(-32'sd100, -32'sd7, "neg_neg");
    runDivide(-32'sd7, 32'd100, "small_neg");

    // Divide by zero.
    runDivide(32'd5, 32'd0, "div_zero");

    // Boundaries.
    runDivide(32'h8000_0000, 32'hFFFF_FFFF, "min_by_m1");
    runDivide(32'h8000_0000, 32'd1, "min_by_1");
    runDivide(32'h7FFF_FFFF, 32'h7FFF_FFFF, "max_by_max");
    runDivide(32'h8000_0000, 32'h8000_0000, "min_by_min");

    // Abort: a second start at cycle 15 replaces the first operation.
    // The first operation must never strobe.
    applyStimulus(32'd1000, 32'd3);
    strobes = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (data_resultRDY) strobes++;
    end
    applyStimulus(32'd81, 32'd9);
    checkOutput("abort.earlyStrobe", 32'(strobes), 32'd0);
    awaitResult(32'd81, 32'd9, "abort");

    // Reset asserted during step 10: every output clears before the next edge.
    applyStimulus(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.result", data_result, 32'd0);
    checkOutput("midReset.exception", 32'(data_exception), 32'd0);
    checkOutput("midReset.rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runDivide(32'd7, 32'd2, "afterReset");

    // A new start right after a divide-by-zero result.
    runDivide(32'hFFFF_FFFF, 32'd0, "div_zero_neg");
    runDivide(32'd1, 32'hFFFF_FFFF, "one_by_m1");

    // Randomized operand pairs with a mix of divisor magnitudes.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (i == 7) rb = 32'd0;
      runDivide(ra, rb, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
